sample_frame_uart: RTL and testbench

- Downstream stage of the ST1/ST2/ST3 acquisition controller.
- Accepts one tagged ADC sample per conversion: a 2-bit channel tag (y1,y0) and a 10-bit ADC word.
- Buffers samples in a small FIFO, then formats each one as three ASCII hex characters plus a comma and serialises them as UART 8N1 on TxD.
- Also drives the 4-digit seven-segment digit select and value for the character being sent.

---
 rtl/sample_frame_uart_pkg.sv | 25 ++
 rtl/sample_frame_uart_if.sv | 10 +
 rtl/sample_frame_uart_fifo.sv | 54 +++++
 rtl/sample_frame_uart.sv | 174 +++++++++++++++++
 tb/tb_sample_frame_uart.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_frame_uart_pkg.sv
// Shared types and helpers for the sample-to-UART framing block.
package sample_frame_uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StData,
      StStop
   } state_e;

   localparam logic [7:0] ASCII_COMMA = 8'h2C;

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // {n0, n1, n2}; data bit 0 (first out of the ADC) lands next to the tag.
   function automatic logic [11:0] pack_nibbles(input logic [1:0] tag, input logic [9:0] data);
      return {tag[1], tag[0], data[0], data[1], data[2], data[3], data[4], data[5],
              data[6], data[7], data[8], data[9]};
   endfunction

endpackage

// File: rtl/sample_frame_uart_if.sv
// Tagged-sample handshake between the acquisition controller and the UART framer.
interface sample_frame_uart_if;
   logic       s_valid;
   logic       s_ready;
   logic [1:0] s_tag;
   logic [9:0] s_data;

   modport master (output s_valid, output s_tag, output s_data, input s_ready);
   modport slave  (input s_valid, input s_tag, input s_data, output s_ready);
endinterface

// File: rtl/sample_frame_uart_fifo.sv
// Synchronous FIFO for packed samples; read data is the current head (fall-through).
module sample_fifo #(
   parameter int unsigned Width = 12,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [Width-1:0]           wdata_i,
   output logic [Width-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth):0]     count_o
);
   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = AddrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q;
   logic [AddrW-1:0] rptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AddrW'(1);
         if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
      end
   end

endmodule

// File: rtl/sample_frame_uart.sv
// Buffers tagged ADC samples and sends each as three hex chars plus a separator, UART 8N1.
module sample_frame_uart
   import sample_frame_uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 10417,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SEP_CHAR   = ASCII_COMMA
) (
   input  logic                sys_clk,
   input  logic                reset_n,
   sample_frame_uart_if.slave  s_if,
   output logic                TxD,
   output logic                busy,
   output logic                frame_done,
   output logic                overflow,
   output logic [3:0]          digit_hex,
   output logic [3:0]          digit_sel
);
   localparam int unsigned          TimerW   = $clog2(CLK_DIV);
   localparam logic [TimerW-1:0]    TimerMax = TimerW'(CLK_DIV - 1);
   localparam int unsigned          CntW     = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q;
   logic [TimerW-1:0] timer_q;
   logic [2:0]        bit_idx_q;
   logic [1:0]        char_idx_q;
   logic [11:0]       word_q;
   logic [3:0][7:0]   chars_q;
   logic              txd_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              overflow_q;
   logic [3:0]        digit_hex_q;
   logic [3:0]        digit_sel_q;

   logic [11:0]       fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CntW-1:0]   fifo_count;
   logic              s_ready;
   logic              fifo_push;
   logic              fifo_pop;

   // Active-low anode for character idx: 0111, 1011, 1101, 1110.
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      return ~(4'b1000 >> idx);
   endfunction

   // Nibble shown on the display for character idx; the separator shows F.
   function automatic logic [3:0] char_nibble(input logic [11:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    return word[11:8];
         2'd1:    return word[7:4];
         2'd2:    return word[3:0];
         default: return 4'hF;
      endcase
   endfunction

   assign s_ready     = (fifo_count != CntW'(FIFO_DEPTH));
   assign s_if.s_ready = s_ready;
   assign fifo_push   = s_if.s_valid && s_ready;
   assign fifo_pop    = (state_q == StIdle) && !fifo_empty;

   sample_fifo #(
      .Width (12),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (sys_clk),
      .rst_ni  (reset_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (pack_nibbles(s_if.s_tag, s_if.s_data)),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Frame sequencer: pop, latch characters, then start/data/stop per character.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         bit_idx_q    <= '0;
         char_idx_q   <= '0;
         word_q       <= '0;
         chars_q      <= '0;
         txd_q        <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         digit_hex_q  <= 4'h0;
         digit_sel_q  <= 4'b1111;
      end else begin
         frame_done_q <= 1'b0;
         // A full FIFO drops the sample even if a pop happens this cycle.
         if (s_if.s_valid && fifo_full) overflow_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               timer_q <= '0;
               if (!fifo_empty) begin
                  word_q  <= fifo_rdata;
                  busy_q  <= 1'b1;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               chars_q[0]  <= nib_to_ascii(word_q[11:8]);
               chars_q[1]  <= nib_to_ascii(word_q[7:4]);
               chars_q[2]  <= nib_to_ascii(word_q[3:0]);
               chars_q[3]  <= SEP_CHAR;
               char_idx_q  <= 2'd0;
               timer_q     <= '0;
               txd_q       <= 1'b0;
               digit_sel_q <= anode_sel(2'd0);
               digit_hex_q <= char_nibble(word_q, 2'd0);
               state_q     <= StStart;
            end
            StStart: begin
               if (timer_q == TimerMax) begin
                  timer_q   <= '0;
                  bit_idx_q <= 3'd0;
                  txd_q     <= chars_q[char_idx_q][0];
                  state_q   <= StData;
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end
            StData: begin
               if (timer_q == TimerMax) begin
                  timer_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     txd_q     <= chars_q[char_idx_q][bit_idx_q + 3'd1];
                  end
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end
            StStop: begin
               if (timer_q == TimerMax) begin
                  timer_q <= '0;
                  if (char_idx_q != 2'd3) begin
                     char_idx_q  <= char_idx_q + 2'd1;
                     txd_q       <= 1'b0;
                     digit_sel_q <= anode_sel(char_idx_q + 2'd1);
                     digit_hex_q <= char_nibble(word_q, char_idx_q + 2'd1);
                     state_q     <= StStart;
                  end else begin
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                     state_q      <= StIdle;
                  end
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign TxD        = txd_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign digit_hex  = digit_hex_q;
   assign digit_sel  = digit_sel_q;

endmodule

// File: tb/tb_sample_frame_uart.sv
// Directed bench: one instance at 4 clocks/bit, one at 2 clocks/bit.
module tb_sample_frame_uart;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   fd_cnt4;
   int   fd_cnt2;

   logic       txd4, busy4, fd4, ovf4;
   logic [3:0] hex4, sel4;
   logic       txd2, busy2, fd2, ovf2;
   logic [3:0] hex2, sel2;

   sample_frame_uart_if sif4 ();
   sample_frame_uart_if sif2 ();

   sample_frame_uart #(
      .CLK_DIV    (4),
      .FIFO_DEPTH (4),
      .SEP_CHAR   (8'h2C)
   ) dut4 (
      .sys_clk    (clk),
      .reset_n    (reset_n),
      .s_if       (sif4),
      .TxD        (txd4),
      .busy       (busy4),
      .frame_done (fd4),
      .overflow   (ovf4),
      .digit_hex  (hex4),
      .digit_sel  (sel4)
   );

   sample_frame_uart #(
      .CLK_DIV    (2),
      .FIFO_DEPTH (4),
      .SEP_CHAR   (8'h2C)
   ) dut2 (
      .sys_clk    (clk),
      .reset_n    (reset_n),
      .s_if       (sif2),
      .TxD        (txd2),
      .busy       (busy2),
      .frame_done (fd2),
      .overflow   (ovf2),
      .digit_hex  (hex2),
      .digit_sel  (sel2)
   );

   // Vector table: tag, data, expected bytes (char0 in MSB), expected display nibbles.
   logic [1:0]  v_tag   [6];
   logic [9:0]  v_data  [6];
   logic [31:0] v_bytes [6];
   logic [15:0] v_hex   [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fd4) fd_cnt4 <= fd_cnt4 + 1;
      if (fd2) fd_cnt2 <= fd_cnt2 + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   function automatic logic txd_of(input int d);
      return (d == 0) ? txd4 : txd2;
   endfunction
   function automatic logic busy_of(input int d);
      return (d == 0) ? busy4 : busy2;
   endfunction
   function automatic logic fd_of(input int d);
      return (d == 0) ? fd4 : fd2;
   endfunction
   function automatic logic [3:0] sel_of(input int d);
      return (d == 0) ? sel4 : sel2;
   endfunction
   function automatic logic [3:0] hex_of(input int d);
      return (d == 0) ? hex4 : hex2;
   endfunction

   task automatic push(input int d, input logic [1:0] tag, input logic [9:0] data);
      if (d == 0) begin
         sif4.s_valid = 1'b1; sif4.s_tag = tag; sif4.s_data = data;
      end else begin
         sif2.s_valid = 1'b1; sif2.s_tag = tag; sif2.s_data = data;
      end
      @(negedge clk);
      sif4.s_valid = 1'b0;
      sif2.s_valid = 1'b0;
   endtask

   // Receives one four-character frame, sampling mid-bit, and checks display and timing.
   task automatic rx_frame(input int d, input logic [31:0] exp_b, input logic [15:0] exp_h,
                           output int fall_cyc, output int done_cyc);
      int         div;
      int         n;
      logic [7:0] b;
      logic [3:0] es;
      div      = (d == 0) ? 4 : 2;
      fall_cyc = 0;
      done_cyc = 0;
      for (int c = 0; c < 4; c++) begin
         n = 0;
         while (txd_of(d) !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
         end
         if (txd_of(d) !== 1'b0) begin
            check("start_timeout", {31'b0, txd_of(d)}, 32'd0);
            return;
         end
         if (c == 0) fall_cyc = cyc;
         es = ~(4'b1000 >> c);
         check("digit_sel", {28'b0, sel_of(d)}, {28'b0, es});
         check("digit_hex", {28'b0, hex_of(d)}, {28'b0, exp_h[15-4*c -: 4]});
         check("busy_in_frame", {31'b0, busy_of(d)}, 32'd1);
         repeat (div / 2) @(negedge clk);
         b = '0;
         for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = txd_of(d);
         end
         check("byte", {24'b0, b}, {24'b0, exp_b[31-8*c -: 8]});
         repeat (div) @(negedge clk);
         check("stop_bit", {31'b0, txd_of(d)}, 32'd1);
      end
      n = 0;
      while (fd_of(d) !== 1'b1 && n < 4 * div) begin
         @(negedge clk);
         n++;
      end
      done_cyc = cyc;
      check("frame_len", done_cyc - fall_cyc, 40 * div);
      check("busy_after_frame", {31'b0, busy_of(d)}, 32'd0);
      check("digit_hold", {28'b0, sel_of(d)}, 32'he);
   endtask

   int f0, d0, f1, d1, t_acc, prev_done, fd_before, n;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; fd_cnt4 = 0; fd_cnt2 = 0;
      v_tag[0] = 2'b10; v_data[0] = 10'h000; v_bytes[0] = 32'h3830302C; v_hex[0] = 16'h800F;
      v_tag[1] = 2'b01; v_data[1] = 10'h3FF; v_bytes[1] = 32'h3746462C; v_hex[1] = 16'h7FFF;
      v_tag[2] = 2'b11; v_data[2] = 10'h001; v_bytes[2] = 32'h4530302C; v_hex[2] = 16'hE00F;
      v_tag[3] = 2'b00; v_data[3] = 10'h200; v_bytes[3] = 32'h3030312C; v_hex[3] = 16'h001F;
      v_tag[4] = 2'b01; v_data[4] = 10'h0AA; v_bytes[4] = 32'h3535342C; v_hex[4] = 16'h554F;
      v_tag[5] = 2'b11; v_data[5] = 10'h3FF; v_bytes[5] = 32'h4646462C; v_hex[5] = 16'hFFFF;
      sif4.s_valid = 1'b0; sif4.s_tag = '0; sif4.s_data = '0;
      sif2.s_valid = 1'b0; sif2.s_tag = '0; sif2.s_data = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_txd", {31'b0, txd4}, 32'd1);
      check("rst_busy", {31'b0, busy4}, 32'd0);
      check("rst_frame_done", {31'b0, fd4}, 32'd0);
      check("rst_overflow", {31'b0, ovf4}, 32'd0);
      check("rst_digit_sel", {28'b0, sel4}, 32'hf);
      check("rst_digit_hex", {28'b0, hex4}, 32'h0);
      check("rst_s_ready", {31'b0, sif4.s_ready}, 32'd1);

      // Single frames with latency and frame_done count
      fd_before = fd_cnt4;
      push(0, v_tag[0], v_data[0]);
      t_acc = cyc;
      rx_frame(0, v_bytes[0], v_hex[0], f0, d0);
      check("latency", f0 - t_acc, 2);
      repeat (3) @(negedge clk);
      check("one_frame_done", fd_cnt4 - fd_before, 1);
      for (int k = 1; k < 4; k++) begin
         push(0, v_tag[k], v_data[k]);
         rx_frame(0, v_bytes[k], v_hex[k], f0, d0);
      end

      // Reset mid-frame with a second sample queued
      repeat (5) @(negedge clk);
      fd_before = fd_cnt4;
      sif4.s_valid = 1'b1; sif4.s_tag = v_tag[0]; sif4.s_data = v_data[0];
      @(negedge clk);
      sif4.s_tag = v_tag[1]; sif4.s_data = v_data[1];
      @(negedge clk);
      sif4.s_valid = 1'b0;
      n = 0;
      while (txd4 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_rst_fall", {31'b0, txd4}, 32'd0);
      repeat (90) @(negedge clk);
      check("mid_rst_busy_before", {31'b0, busy4}, 32'd1);
      reset_n = 1'b0;
      sif4.s_valid = 1'b1; sif4.s_tag = v_tag[2]; sif4.s_data = v_data[2];
      @(negedge clk);
      sif4.s_valid = 1'b0;
      check("mid_rst_txd", {31'b0, txd4}, 32'd1);
      check("mid_rst_busy", {31'b0, busy4}, 32'd0);
      check("mid_rst_digit_sel", {28'b0, sel4}, 32'hf);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (60) @(negedge clk);
      check("mid_rst_fifo_empty", {31'b0, busy4}, 32'd0);
      check("mid_rst_txd_idle", {31'b0, txd4}, 32'd1);
      check("mid_rst_no_done", fd_cnt4 - fd_before, 0);
      push(0, v_tag[5], v_data[5]);
      rx_frame(0, v_bytes[5], v_hex[5], f0, d0);

      // Overflow: six pushes on consecutive cycles, five frames back to back
      repeat (5) @(negedge clk);
      fd_before = fd_cnt4;
      check("ovf_clear_before", {31'b0, ovf4}, 32'd0);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               sif4.s_valid = 1'b1; sif4.s_tag = v_tag[i]; sif4.s_data = v_data[i];
               check("ovf_s_ready", {31'b0, sif4.s_ready}, (i < 5) ? 32'd1 : 32'd0);
               @(negedge clk);
               if (i >= 4) check("ovf_flag", {31'b0, ovf4}, (i == 5) ? 32'd1 : 32'd0);
            end
            sif4.s_valid = 1'b0;
         end
         begin
            prev_done = 0;
            for (int k = 0; k < 5; k++) begin
               rx_frame(0, v_bytes[k], v_hex[k], f1, d1);
               if (k > 0) check("b2b_gap", f1 - prev_done, 2);
               prev_done = d1;
            end
         end
      join
      repeat (200) @(negedge clk);
      check("ovf_five_done", fd_cnt4 - fd_before, 5);
      check("ovf_idle_busy", {31'b0, busy4}, 32'd0);
      check("ovf_idle_ready", {31'b0, sif4.s_ready}, 32'd1);
      check("ovf_sticky", {31'b0, ovf4}, 32'd1);

      // Two clocks per bit, back to back
      fork
         begin
            push(1, v_tag[4], v_data[4]);
            t_acc = cyc;
            push(1, v_tag[2], v_data[2]);
         end
         begin
            rx_frame(1, v_bytes[4], v_hex[4], f0, d0);
            rx_frame(1, v_bytes[2], v_hex[2], f1, d1);
         end
      join
      check("div2_latency", f0 - t_acc, 2);
      check("div2_gap", f1 - d0, 2);
      repeat (3) @(negedge clk);
      check("div2_done_count", fd_cnt2, 2);

      // Overflow clears only on reset
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ovf_cleared", {31'b0, ovf4}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
